// File: rtl/mem_bus_defs_pkg.sv
// Shared definitions for the CPU data-memory bus: FSM encodings, word size,
// request-type codes and the latched request record.
package mem_bus_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int   WORD_BYTES = 4;
  localparam logic REQ_LOAD   = 1'b0;
  localparam logic REQ_STORE  = 1'b1;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word storage: synchronous write, combinational read by word index.
// Contents are deliberately not reset.
module mem_array_sp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdata_i;
  end

  assign rdata_o = mem[idx_i];

endmodule

// File: rtl/mem_wait_responder.sv
// Handshaked, wait-stated data-memory responder for the CPU load/store port.
// Define MEM_ALIGN_CHECK_EN to fault word accesses with addr[1:0] != 0.
module mem_wait_responder
  import mem_bus_defs::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(WAIT_CYCLES + 2);
  localparam logic [32:0]   LIMIT    = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
  // One extra count covers the handshake cycle, so WAIT_CYCLES=0 still
  // spends one cycle in WAIT and the response lands T+1+WAIT_CYCLES.
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_req_t      req_q, req_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic          hs, req_err, enter_resp, arr_we;
  logic [31:0]   arr_rdata;

  assign hs         = (state_q == ST_IDLE) && req_valid_i && req_ready_q;
  assign enter_resp = (state_q == ST_WAIT) && (cnt_q == CW'(1));

`ifdef MEM_ALIGN_CHECK_EN
  assign req_err = ({1'b0, req_q.addr} >= LIMIT) || (req_q.addr[1:0] != 2'b00);
`else
  assign req_err = ({1'b0, req_q.addr} >= LIMIT);
`endif

  assign arr_we = enter_resp && (req_q.write == REQ_STORE) && !req_err;

  mem_array_sp #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .idx_i   (req_q.addr[AW+1:2]),
    .wdata_i (req_q.wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs)          state_d = ST_WAIT;
      ST_WAIT: if (enter_resp)  state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready_d = (state_d == ST_IDLE);
    if (hs) begin
      req_d = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i};
      cnt_d = CNT_LOAD;
    end
    if (state_q == ST_WAIT) cnt_d = cnt_q - CW'(1);
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      rsp_rdata_d = ((req_q.write == REQ_LOAD) && !req_err) ? arr_rdata : '0;
    end
    if ((state_q == ST_RESP) && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: WAIT_CYCLES=2 main instance plus a
// WAIT_CYCLES=0 instance for the zero-wait latency case.
module tb_mem_wait_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        r1_req_valid = 1'b0, r1_req_write = 1'b0, r1_rsp_ready = 1'b0;
  logic [31:0] r1_req_addr = '0, r1_req_wdata = '0;
  logic        r1_req_ready, r1_rsp_valid, r1_rsp_err;
  logic [31:0] r1_rsp_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  mem_wait_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  mem_wait_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(r1_req_valid), .req_ready_o(r1_req_ready), .req_write_i(r1_req_write),
    .req_addr_i(r1_req_addr), .req_wdata_i(r1_req_wdata),
    .rsp_valid_o(r1_rsp_valid), .rsp_ready_i(r1_rsp_ready),
    .rsp_rdata_o(r1_rsp_rdata), .rsp_err_o(r1_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request once ready is seen; returns 1ns after the handshake edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int l);
    l = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      l++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) l = -1;
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_valid_clr"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_ready_set"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int l;
    issue(w, a, d);
    wait_rsp(l);
    chk({tag, "_lat"}, 32'(l), 32'd3);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    consume(tag);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_ready_high", {31'd0, req_ready}, 32'd1);

    // Store then load, exact latency
    access("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Backpressure with a competing request that must be ignored
    issue(1'b0, 32'h10, 32'h0);
    wait_rsp(lat);
    chk("bp_lat", 32'(lat), 32'd3);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_err", {31'd0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    consume("bp");
    access("ld10_after_bp", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Out of range
    access("st_ffc", 1'b1, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0);
    access("st_000", 1'b1, 32'h0, 32'h01020304, 32'h0, 1'b0);
    access("st_oor", 1'b1, 32'h1000, 32'h12345678, 32'h0, 1'b1);
    access("ld_ffc", 1'b0, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0);
    access("ld_000", 1'b0, 32'h0, 32'h0, 32'h01020304, 1'b0);
    access("ld_oor", 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
    access("ld_top", 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);

    // Reset while a store waits drops the store
    access("st20_old", 1'b1, 32'h20, 32'h5A5A0001, 32'h0, 1'b0);
    issue(1'b1, 32'h20, 32'hAAAA5555);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_ready_back", {31'd0, req_ready}, 32'd1);
    access("ld20_old", 1'b0, 32'h20, 32'h0, 32'h5A5A0001, 1'b0);

    // Misaligned load
`ifdef MEM_ALIGN_CHECK_EN
    access("ld22", 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);
`else
    access("ld22", 1'b0, 32'h22, 32'h0, 32'h5A5A0001, 1'b0);
`endif

    // Zero-wait instance: response one edge after handshake
    chk("w0_ready", {31'd0, r1_req_ready}, 32'd1);
    r1_req_valid = 1'b1; r1_req_write = 1'b1; r1_req_addr = 32'h40; r1_req_wdata = 32'h13579BDF;
    @(posedge clk); #1;
    r1_req_valid = 1'b0;
    chk("w0_st_pending", {31'd0, r1_rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("w0_st_valid", {31'd0, r1_rsp_valid}, 32'd1);
    chk("w0_st_err", {31'd0, r1_rsp_err}, 32'd0);
    r1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    r1_rsp_ready = 1'b0;
    chk("w0_st_clr", {31'd0, r1_rsp_valid}, 32'd0);
    r1_req_valid = 1'b1; r1_req_write = 1'b0; r1_req_addr = 32'h40;
    @(posedge clk); #1;
    r1_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("w0_ld_valid", {31'd0, r1_rsp_valid}, 32'd1);
    chk("w0_ld_rdata", r1_rsp_rdata, 32'h13579BDF);
    r1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    r1_rsp_ready = 1'b0;
    chk("w0_ld_clr", {31'd0, r1_rsp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
